dcache_ctrl: RTL

// - Direct-mapped, write-back, write-allocate L1 data cache.
// - Sits between the CPU MEM stage (EX/MEM address, store data, MemRead/MemWrite) and a multi-cycle line-wide data memory.
// - Hits complete in the same cycle with no stall.
// - Misses raise cpu_stall_o, which freezes every pipeline register until the line is resident.

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_sram.sv | 53 +++++
 rtl/dcache_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared constants, FSM encoding and line/word helpers for the direct-mapped
// write-back data cache.
package dcache_pkg;

  localparam int NUM_LINES = 32;
  localparam int IDX_W     = $clog2(NUM_LINES);
  localparam int OFF_W     = 5;
  localparam int ADDR_W    = 32;
  localparam int TAG_W     = ADDR_W - OFF_W - IDX_W;
  localparam int LINE_W    = 256;
  localparam int WORD_W    = 32;
  localparam int WSEL_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2,
    ST_REFILL    = 2'd3
  } state_t;

  function automatic logic [WORD_W-1:0] line_get_word(
    input logic [LINE_W-1:0] line,
    input logic [WSEL_W-1:0] sel
  );
    return line[sel*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous write.
// Only valid/dirty are reset; tag and data contents are don't-care until valid.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [LINE_W-1:0] o_line,
  input  logic              i_line_we,
  input  logic [TAG_W-1:0]  i_line_tag,
  input  logic [LINE_W-1:0] i_line_data,
  input  logic              i_word_we,
  input  logic [WSEL_W-1:0] i_word_sel,
  input  logic [WORD_W-1:0] i_word_data
);

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  // A full-line fill always leaves the line clean; a word store marks it dirty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_line_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_word_we) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_line_we) begin
      r_tag[i_idx]  <= i_line_tag;
      r_data[i_idx] <= i_line_data;
    end else if (i_word_we) begin
      r_data[i_idx][i_word_sel*WORD_W +: WORD_W] <= i_word_data;
    end
  end

  assign o_tag   = r_tag[i_idx];
  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_line  = r_data[i_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back / write-allocate L1 data cache controller:
// same-cycle hits, stall-and-refill on misses with optional victim writeback.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output state_t            dbg_state_o
);

  // Memory handshake: mem_enable_o is held with a stable address/direction
  // until the single-cycle mem_ack_i; the request is complete on that edge.

  state_t r_state;
  state_t w_state_nxt;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [WSEL_W-1:0] w_wsel;
  logic              w_req;
  logic              w_is_write;
  logic              w_hit;
  logic              w_unused_addr;

  logic [TAG_W-1:0]  w_line_tag;
  logic              w_line_valid;
  logic              w_line_dirty;
  logic [LINE_W-1:0] w_line;

  logic              w_line_we;
  logic              w_word_we;
  logic              w_stall;
  logic              w_mem_en;
  logic              w_mem_wr;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [LINE_W-1:0] w_mem_data;
  logic [WORD_W-1:0] w_rdata;

  assign w_tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign w_idx         = cpu_addr_i[OFF_W +: IDX_W];
  assign w_wsel        = cpu_addr_i[OFF_W-1:2];
  assign w_unused_addr = ^cpu_addr_i[1:0];
  assign w_req         = cpu_MemRead_i | cpu_MemWrite_i;
  assign w_is_write    = cpu_MemWrite_i;
  assign w_hit         = w_line_valid & (w_line_tag == w_tag);

  dcache_sram u_sram (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_idx       (w_idx),
    .o_tag       (w_line_tag),
    .o_valid     (w_line_valid),
    .o_dirty     (w_line_dirty),
    .o_line      (w_line),
    .i_line_we   (w_line_we),
    .i_line_tag  (w_tag),
    .i_line_data (mem_data_i),
    .i_word_we   (w_word_we),
    .i_word_sel  (w_wsel),
    .i_word_data (cpu_data_i)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_mem_en    = 1'b0;
    w_mem_wr    = 1'b0;
    w_mem_addr  = '0;
    w_mem_data  = '0;
    w_line_we   = 1'b0;
    w_word_we   = 1'b0;
    w_rdata     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            if (w_is_write) begin
              w_word_we = 1'b1;
            end else begin
              w_rdata = line_get_word(w_line, w_wsel);
            end
          end else begin
            w_stall     = 1'b1;
            w_state_nxt = (w_line_valid && w_line_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
          end
        end
      end
      ST_WRITEBACK: begin
        w_stall    = 1'b1;
        w_mem_en   = 1'b1;
        w_mem_wr   = 1'b1;
        w_mem_addr = {w_line_tag, w_idx, {OFF_W{1'b0}}};
        w_mem_data = w_line;
        if (mem_ack_i) begin
          w_state_nxt = ST_ALLOCATE;
        end
      end
      ST_ALLOCATE: begin
        w_stall    = 1'b1;
        w_mem_en   = 1'b1;
        w_mem_addr = {w_tag, w_idx, {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          w_line_we   = 1'b1;
          w_state_nxt = ST_REFILL;
        end
      end
      ST_REFILL: begin
        w_stall     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // Reset silences every output and write strobe immediately, even mid-miss.
    if (rst_i) begin
      w_stall    = 1'b0;
      w_mem_en   = 1'b0;
      w_mem_wr   = 1'b0;
      w_mem_addr = '0;
      w_mem_data = '0;
      w_line_we  = 1'b0;
      w_word_we  = 1'b0;
      w_rdata    = '0;
    end
  end

  assign cpu_data_o   = w_rdata;
  assign cpu_stall_o  = w_stall;
  assign mem_enable_o = w_mem_en;
  assign mem_write_o  = w_mem_wr;
  assign mem_addr_o   = w_mem_addr;
  assign mem_data_o   = w_mem_data;
  assign dbg_state_o  = r_state;

endmodule
